conv_interleaver: RTL

CONV_INTERLEAVER -- requirements
Module: conv_interleaver

---
 rtl/conv_il_pkg.sv | 20 ++
 rtl/conv_il_ram.sv | 30 +++
 rtl/conv_interleaver.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/conv_il_pkg.sv
// Shared constants and storage-layout helpers for the convolutional interleaver.
package conv_il_pkg;

   localparam int unsigned DefBranches = 12;
   localparam int unsigned DefDepthM   = 17;

   localparam int unsigned DvbI      = 12;
   localparam int unsigned DvbM      = 17;
   localparam int unsigned DvbPktLen = 204;

   function automatic int unsigned total_cells(int unsigned branches, int unsigned depth_m);
      return depth_m * branches * (branches - 1) / 2;
   endfunction

   // Branch with delay index bd starts after the cells of all shorter branches.
   function automatic int unsigned base_offset(int unsigned depth_m, int unsigned bd);
      return (bd == 0) ? 0 : depth_m * bd * (bd - 1) / 2;
   endfunction

endpackage

// File: rtl/conv_il_ram.sv
// Simple dual-port RAM with registered read; a same-address access returns the old word.
module conv_il_ram #(
   parameter int unsigned Width = 9,
   parameter int unsigned Depth = 1122,
   parameter int unsigned AddrW = 11
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_interleaver.sv
// Forney convolutional (de)interleaver: a commutator over BRANCHES FIFOs of growing depth,
// all packed into one RAM, with sync re-alignment and masking of unfilled branches.
module conv_interleaver
   import conv_il_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned BRANCHES = DefBranches,
   parameter int unsigned DEPTH_M  = DefDepthM,
   parameter int unsigned DEINT    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   input  logic              din_sync,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              dout_sync,
   output logic              sync_err,
   output logic              primed
);

   localparam int unsigned Cells = total_cells(BRANCHES, DEPTH_M);
   localparam int unsigned AW    = (Cells > 1) ? $clog2(Cells) : 1;
   localparam int unsigned MaxD  = (BRANCHES - 1) * DEPTH_M;
   localparam int unsigned PW    = $clog2(MaxD + 1);
   localparam int unsigned BW    = $clog2(BRANCHES);
   localparam int unsigned WW    = DATA_W + 1;

   logic [PW-1:0] dlen_tbl [BRANCHES];
   logic [AW-1:0] base_tbl [BRANCHES];

   for (genvar g = 0; g < BRANCHES; g++) begin : g_tbl
      localparam int unsigned Bd = (DEINT != 0) ? (BRANCHES - 1 - unsigned'(g)) : unsigned'(g);
      assign dlen_tbl[g] = PW'(Bd * DEPTH_M);
      assign base_tbl[g] = AW'(base_offset(DEPTH_M, Bd));
   end

   logic [BW-1:0]       comm_q, comm_d;
   logic [PW-1:0]       ptr_q [BRANCHES];
   logic [PW-1:0]       ptr_d [BRANCHES];
   logic [BRANCHES-1:0] filled_q, filled_d;
   logic                primed_q, primed_d;
   logic                vld_q, vld_d;
   logic                err_q, err_d;
   logic                pass_q, pass_d;
   logic                mask_q, mask_d;
   logic [WW-1:0]       word_q, word_d;

   logic          misalign;
   logic [BW-1:0] cur_b;
   logic [PW-1:0] cur_len, cur_ptr;
   logic          is_pass, ptr_wrap, ram_en;
   logic [AW-1:0] ram_addr;
   logic [WW-1:0] ram_rdata, out_word;

   // A sync seen off branch 0 is forced onto branch 0 to re-align the commutator.
   assign misalign = din_sync && (comm_q != '0);
   assign cur_b    = misalign ? '0 : comm_q;
   assign cur_len  = dlen_tbl[cur_b];
   assign cur_ptr  = ptr_q[cur_b];
   assign is_pass  = (cur_len == '0);
   assign ptr_wrap = (cur_ptr == cur_len - PW'(1));
   assign ram_en   = din_valid && !rst && !is_pass;
   assign ram_addr = base_tbl[cur_b] + AW'(cur_ptr);

   conv_il_ram #(
      .Width(WW),
      .Depth(Cells),
      .AddrW(AW)
   ) u_ram (
      .clk_i  (clk),
      .we_i   (ram_en),
      .waddr_i(ram_addr),
      .wdata_i({din_sync, din}),
      .re_i   (ram_en),
      .raddr_i(ram_addr),
      .rdata_o(ram_rdata)
   );

   always_comb begin
      comm_d   = comm_q;
      ptr_d    = ptr_q;
      filled_d = filled_q;
      primed_d = primed_q | (&filled_q);
      vld_d    = din_valid;
      err_d    = din_valid && misalign;
      pass_d   = pass_q;
      mask_d   = mask_q;
      word_d   = word_q;
      if (din_valid) begin
         comm_d = (cur_b == BW'(BRANCHES - 1)) ? '0 : cur_b + BW'(1);
         pass_d = is_pass;
         mask_d = ~filled_q[cur_b];
         word_d = {din_sync, din};
         if (!is_pass) begin
            ptr_d[cur_b] = ptr_wrap ? '0 : cur_ptr + PW'(1);
         end
         if (is_pass || ptr_wrap) begin
            filled_d[cur_b] = 1'b1;
         end
      end
   end

   // Memory is left untouched by reset; the filled bits hide whatever it holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         comm_q   <= '0;
         filled_q <= '0;
         primed_q <= 1'b0;
         vld_q    <= 1'b0;
         err_q    <= 1'b0;
         pass_q   <= 1'b0;
         mask_q   <= 1'b0;
         word_q   <= '0;
         for (int i = 0; i < BRANCHES; i++) begin
            ptr_q[i] <= '0;
         end
      end else begin
         comm_q   <= comm_d;
         filled_q <= filled_d;
         primed_q <= primed_d;
         vld_q    <= vld_d;
         err_q    <= err_d;
         pass_q   <= pass_d;
         mask_q   <= mask_d;
         word_q   <= word_d;
         for (int i = 0; i < BRANCHES; i++) begin
            ptr_q[i] <= ptr_d[i];
         end
      end
   end

   always_comb begin
      out_word = '0;
      if (vld_q) begin
         if (pass_q) begin
            out_word = word_q;
         end else if (!mask_q) begin
            out_word = ram_rdata;
         end
      end
   end

   assign dout       = out_word[DATA_W-1:0];
   assign dout_sync  = out_word[DATA_W];
   assign dout_valid = vld_q;
   assign sync_err   = err_q;
   assign primed     = primed_q;

endmodule
